// File: rtl/serial_add_sub_pkg.sv
// Shared types and constants for the digit-serial adder/subtracter.
package serial_add_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_DIGIT = 4;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Digit counter width; never zero so the single-slice case still has a register.
   function automatic int cnt_width(input int width, input int digit);
      int w;
      w = clog2(width / digit);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/serial_add_digit.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into its top bit
// so the caller can derive two's-complement overflow.
module serial_add_digit #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout,
   output logic             c_msb_in
);

   always_comb begin
      logic [DIGIT:0] c;
      // NOTE: blocking assignments here make the carry ripple through the loop in bit order.
      c        = '0;
      sum      = '0;
      c[0]     = cin;
      for (int i = 0; i < DIGIT; i++) begin
         sum[i]   = x[i] ^ y[i] ^ c[i];
         c[i + 1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
      end
      cout     = c[DIGIT];
      c_msb_in = c[DIGIT - 1];
   end

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtracter: one DIGIT-wide slice per RUN cycle, LSB slice
// first, result published on s/co/ovf only at the completion edge.
module serial_add_sub
   import serial_add_sub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DIGIT = DEF_DIGIT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = cnt_width(WIDTH, DIGIT);
   localparam int IW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   generate
      if (DIGIT < 1) begin : g_bad_digit
         $error("serial_add_sub: DIGIT must be >= 1");
      end else if ((WIDTH % DIGIT) != 0) begin : g_bad_width
         $error("serial_add_sub: WIDTH must be a multiple of DIGIT");
      end
   endgenerate

   state_t           state, state_next;
   logic [WIDTH-1:0] a_q, b_q, res_q, res_next;
   logic [CW-1:0]    cnt_q;
   logic             carry_q;
   logic [IW-1:0]    idx;
   logic             accept, last;
   logic [DIGIT-1:0] slice_sum;
   logic             slice_cout, slice_c_msb;

   assign accept = start && ((state == IDLE) || (state == DONE));
   assign last   = (state == RUN) && (cnt_q == LAST);
   assign idx    = IW'(cnt_q * DIGIT);

   serial_add_digit #(.DIGIT(DIGIT)) u_digit (
      .x        (a_q[idx +: DIGIT]),
      .y        (b_q[idx +: DIGIT]),
      .cin      (carry_q),
      .sum      (slice_sum),
      .cout     (slice_cout),
      .c_msb_in (slice_c_msb)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = RUN;
         RUN:     if (last)   state_next = DONE;
         DONE:    state_next = accept ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   // Partial sums accumulate here, never on s.
   always_comb begin
      res_next                = res_q;
      res_next[idx +: DIGIT]  = slice_sum;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         s       <= '0;
         co      <= 1'b0;
         ovf     <= 1'b0;
      end else if (accept) begin
         // NOTE: non-blocking so every register sees the pre-edge values of the others.
         a_q     <= a;
         b_q     <= b ^ {WIDTH{sub}};
         carry_q <= ci ^ sub;
         cnt_q   <= '0;
      end else if (state == RUN) begin
         res_q   <= res_next;
         carry_q <= slice_cout;
         cnt_q   <= cnt_q + 1'b1;
         if (last) begin
            s   <= res_next;
            co  <= slice_cout;
            ovf <= slice_c_msb ^ slice_cout;
         end
      end
   end

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_serial_add_sub;

   localparam int WIDTH = 16;
   localparam int DIGIT = 4;
   localparam int N     = WIDTH / DIGIT;

   logic             clk = 1'b0;
   logic             rst, start, ci, sub;
   logic [WIDTH-1:0] a, b, s;
   logic             busy, done, co, ovf;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   serial_add_sub #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .ci    (ci),
      .sub   (sub),
      .busy  (busy),
      .done  (done),
      .s     (s),
      .co    (co),
      .ovf   (ovf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: whole-word arithmetic; overflow from the sign rule.
   function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                         input logic op_sub, input logic cin_raw);
      logic [15:0] ey;
      logic [16:0] full;
      logic        v;
      ey   = op_sub ? ~y : y;
      full = {1'b0, x} + {1'b0, ey} + {16'd0, cin_raw ^ op_sub};
      v    = (x[15] == ey[15]) && (full[15] != x[15]);
      return {v, full[16], full[15:0]};
   endfunction

   task automatic launch(input logic [15:0] x, input logic [15:0] y,
                         input logic op_sub, input logic cin_raw);
      a     = x;
      b     = y;
      sub   = op_sub;
      ci    = cin_raw;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat, output int bcnt);
      lat  = 0;
      bcnt = 0;
      while (!done && lat < 20) begin
         if (busy) bcnt++;
         @(negedge clk);
         lat++;
      end
      if (!done) check("done_timeout", {31'd0, done}, 32'd1);
   endtask

   task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic op_sub, input logic cin_raw,
                         input logic [15:0] exp_s, input logic exp_co, input logic exp_ovf);
      int lat, bcnt;
      launch(x, y, op_sub, cin_raw);
      wait_done(lat, bcnt);
      check({tag, "_latency"}, lat, N);
      check({tag, "_busy_cycles"}, bcnt, N);
      check({tag, "_s"}, {16'd0, s}, {16'd0, exp_s});
      check({tag, "_co"}, {31'd0, co}, {31'd0, exp_co});
      check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
      check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      @(negedge clk);
      check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      logic [17:0]      m;
      logic [15:0]      rx, ry;
      logic             rs, rc;
      int               lat, bcnt, d1, d2, dn;

      rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0; ci = 1'b0;
      #12;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_s",    {16'd0, s},    32'd0);
      check("rst_co",   {31'd0, co},   32'd0);
      check("rst_ovf",  {31'd0, ovf},  32'd0);

      // First start right at deassertion must be taken on the next edge.
      @(negedge clk);
      rst = 1'b0;
      run_op("add_basic",  16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
      run_op("sub_neg",    16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
      run_op("sub_borrow", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);
      run_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_op("sub_ovf",    16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
      run_op("add_cin",    16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

      for (int i = 0; i < 40; i++) begin
         rx = 16'($urandom);
         ry = 16'($urandom);
         rs = 1'($urandom);
         rc = 1'($urandom);
         m  = model(rx, ry, rs, rc);
         run_op($sformatf("rand%0d", i), rx, ry, rs, rc, m[15:0], m[16], m[17]);
      end

      // start pulsed during RUN must not disturb the operation in flight.
      launch(16'h0F0F, 16'h0101, 1'b0, 1'b0);
      a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; start = 1'b1;
      @(negedge clk);
      a = 16'h1234; b = 16'h4321; sub = 1'b0;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, bcnt);
      check("ign_latency", lat, N - 2);
      check("ign_s", {16'd0, s}, 32'h0000_1010);
      dn = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) dn++;
      end
      check("ign_extra_done", dn, 0);

      // Back-to-back: start held in the DONE cycle.
      launch(16'h1000, 16'h0234, 1'b0, 1'b0);
      wait_done(lat, bcnt);
      d1 = cyc;
      check("b2b_first_s", {16'd0, s}, 32'h0000_1234);
      launch(16'h5000, 16'h1000, 1'b1, 1'b0);
      wait_done(lat, bcnt);
      d2 = cyc;
      check("b2b_gap", d2 - d1, N + 1);
      check("b2b_second_s", {16'd0, s}, 32'h0000_4000);
      @(negedge clk);

      // Reset mid-RUN abandons the operation immediately.
      launch(16'h1111, 16'h2222, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_done", {31'd0, done}, 32'd0);
      check("mid_rst_s",    {16'd0, s},    32'd0);
      @(negedge clk);
      rst = 1'b0;
      dn = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) dn++;
      end
      check("mid_rst_no_done", dn, 0);
      check("mid_rst_s_hold", {16'd0, s}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
